// File: rtl/reset_sequencer.sv
// Staged reset-release controller: releases stage_reset_o one stage at a time after sync_reset_i drops.
// Define RESET_SEQ_ACK_EN to gate each release on the previous stage's ack, with timeout/error.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGE_DELAY    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  sync_reset_i,
    input  logic [NUM_STAGES-1:0] stage_ack_i,
    output logic [NUM_STAGES-1:0] stage_reset_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int MAX_AB = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int MAXC   = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int KW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {HOLD, WAIT, DONE, ERROR} state_t;

    state_t                  state_reg, state_next;
    logic [KW-1:0]           k_reg, k_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_STAGES-1:0]   stage_reset_reg, stage_reset_next;
    logic                    done_reg, done_next;
    logic                    hold_done;
    logic                    advance;
    logic                    last_stage;
    logic [NUM_STAGES-1:0]   release_hit;

    assign hold_done  = (state_reg == HOLD) && (cnt_reg >= CW'(HOLD_CYCLES));
    assign last_stage = (k_reg == KW'(NUM_STAGES - 1));

`ifdef RESET_SEQ_ACK_EN
    logic timeout;
    logic error_reg, error_next;

    // k is the most recently released stage, so its ack gates the next release.
    assign advance = (state_reg == WAIT) && (cnt_reg >= CW'(STAGE_DELAY)) && stage_ack_i[k_reg];
    assign timeout = (state_reg == WAIT) && (cnt_reg >= CW'(TIMEOUT_CYCLES));
`else
    logic unused_ack;

    assign unused_ack = ^stage_ack_i;
    assign advance    = (state_reg == WAIT) && (cnt_reg >= CW'(STAGE_DELAY));
`endif

    // One release strobe per stage; stage 0 comes from the hold phase, others from WAIT.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_release
            if (gi == 0) begin : g_first
                assign release_hit[gi] = hold_done;
            end else begin : g_rest
                assign release_hit[gi] = advance && (k_reg == KW'(gi - 1));
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (sync_reset_i) begin
            state_reg       <= HOLD;
            k_reg           <= '0;
            cnt_reg         <= '0;
            stage_reset_reg <= '1;
            done_reg        <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
            error_reg       <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            cnt_reg         <= cnt_next;
            stage_reset_reg <= stage_reset_next;
            done_reg        <= done_next;
`ifdef RESET_SEQ_ACK_EN
            error_reg       <= error_next;
`endif
        end
    end

    // Next-state logic. The counter restarts at 1 on a release so that it equals
    // the number of edges elapsed since that release when compared.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            HOLD: begin
                if (hold_done) begin
                    state_next = WAIT;
                    k_next     = '0;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT: begin
                if (advance) begin
                    if (last_stage) begin
                        state_next = DONE;
                    end else begin
                        k_next   = k_reg + KW'(1);
                        cnt_next = CW'(1);
                    end
`ifdef RESET_SEQ_ACK_EN
                end else if (timeout) begin
                    state_next = ERROR;
`endif
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase
    end

    // Output logic: next values for the registered outputs; released stages stay released.
    always_comb begin
        stage_reset_next = stage_reset_reg & ~release_hit;
        done_next        = done_reg | (advance && last_stage);
`ifdef RESET_SEQ_ACK_EN
        error_next       = error_reg | (timeout && !advance);
`endif
    end

    assign stage_reset_o = stage_reset_reg;
    assign done_o        = done_reg;
`ifdef RESET_SEQ_ACK_EN
    assign error_o       = error_reg;
`else
    assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected outputs at given edges are queued, a monitor checks them.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic [3:0] stage_ack = 4'b1111;
    logic [3:0] stage_reset;
    logic       done;
    logic       error;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int         edge_no;
        logic [3:0] sr;
        logic       d;
        logic       e;
        int         tag;
    } exp_t;

    exp_t sb[$];

    reset_sequencer #(
        .NUM_STAGES(4),
        .HOLD_CYCLES(8),
        .STAGE_DELAY(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .sync_reset_i(sync_reset),
        .stage_ack_i(stage_ack),
        .stage_reset_o(stage_reset),
        .done_o(done),
        .error_o(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int e, input logic [3:0] sr, input logic d, input logic er, input int tag);
        exp_t x;
        x.edge_no = e;
        x.sr = sr;
        x.d = d;
        x.e = er;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compares each queued expectation at the negedge after its edge.
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
            x = sb.pop_front();
            compared++;
            if (x.edge_no != cyc || stage_reset !== x.sr || done !== x.d || error !== x.e) begin
                mismatched++;
                $display("FAIL t%0d edge%0d: got sr=%b done=%b err=%b (cyc %0d), required sr=%b done=%b err=%b",
                         x.tag, x.edge_no, stage_reset, done, error, cyc, x.sr, x.d, x.e);
            end else begin
                $display("ok   t%0d edge%0d: sr=%b done=%b err=%b", x.tag, x.edge_no, stage_reset, done, error);
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);

        // T1: plain time-mode release (ack all ones behaves identically in ack builds)
        base = cyc + 1;
        expect_at(base + 7,  4'b1111, 1'b0, 1'b0, 1);
        expect_at(base + 8,  4'b1110, 1'b0, 1'b0, 1);
        expect_at(base + 23, 4'b1110, 1'b0, 1'b0, 1);
        expect_at(base + 24, 4'b1100, 1'b0, 1'b0, 1);
        expect_at(base + 39, 4'b1100, 1'b0, 1'b0, 1);
        expect_at(base + 40, 4'b1000, 1'b0, 1'b0, 1);
        expect_at(base + 55, 4'b1000, 1'b0, 1'b0, 1);
        expect_at(base + 56, 4'b0000, 1'b0, 1'b0, 1);
        expect_at(base + 71, 4'b0000, 1'b0, 1'b0, 1);
        expect_at(base + 72, 4'b0000, 1'b1, 1'b0, 1);
        expect_at(base + 100, 4'b0000, 1'b1, 1'b0, 1);
        sync_reset = 1'b0;
        until_cyc(base + 110);
        sync_reset = 1'b1;
        repeat (2) @(negedge clk);

        // T2: reset re-asserted mid-sequence at edge 30, released from edge 35
        base = cyc + 1;
        expect_at(base + 29, 4'b1100, 1'b0, 1'b0, 2);
        expect_at(base + 30, 4'b1111, 1'b0, 1'b0, 2);
        expect_at(base + 42, 4'b1111, 1'b0, 1'b0, 2);
        expect_at(base + 43, 4'b1110, 1'b0, 1'b0, 2);
        expect_at(base + 58, 4'b1110, 1'b0, 1'b0, 2);
        expect_at(base + 59, 4'b1100, 1'b0, 1'b0, 2);
        expect_at(base + 75, 4'b1000, 1'b0, 1'b0, 2);
        expect_at(base + 91, 4'b0000, 1'b0, 1'b0, 2);
        expect_at(base + 106, 4'b0000, 1'b0, 1'b0, 2);
        expect_at(base + 107, 4'b0000, 1'b1, 1'b0, 2);
        sync_reset = 1'b0;
        until_cyc(base + 29);
        sync_reset = 1'b1;
        until_cyc(base + 34);
        sync_reset = 1'b0;
        until_cyc(base + 110);

        // T3: reset held high for 200 cycles
        sync_reset = 1'b1;
        base = cyc + 1;
        for (int i = 0; i < 200; i++) expect_at(base + i, 4'b1111, 1'b0, 1'b0, 3);
        until_cyc(base + 199);
        repeat (2) @(negedge clk);

`ifdef RESET_SEQ_ACK_EN
        // T4: ack[0] first seen at edge 40, ack[1] never -> timeout at 104
        stage_ack = 4'b0000;
        base = cyc + 1;
        expect_at(base + 24, 4'b1110, 1'b0, 1'b0, 4);
        expect_at(base + 39, 4'b1110, 1'b0, 1'b0, 4);
        expect_at(base + 40, 4'b1100, 1'b0, 1'b0, 4);
        expect_at(base + 103, 4'b1100, 1'b0, 1'b0, 4);
        expect_at(base + 104, 4'b1100, 1'b0, 1'b1, 4);
        expect_at(base + 140, 4'b1100, 1'b0, 1'b1, 4);
        sync_reset = 1'b0;
        until_cyc(base + 39);
        stage_ack = 4'b0001;
        until_cyc(base + 140);
        sync_reset = 1'b1;
        repeat (2) @(negedge clk);

        // T5: ack[0] early -> release at 24; ack[1] held low -> error at 88
        stage_ack = 4'b0000;
        base = cyc + 1;
        expect_at(base + 23, 4'b1110, 1'b0, 1'b0, 5);
        expect_at(base + 24, 4'b1100, 1'b0, 1'b0, 5);
        expect_at(base + 87, 4'b1100, 1'b0, 1'b0, 5);
        expect_at(base + 88, 4'b1100, 1'b0, 1'b1, 5);
        expect_at(base + 120, 4'b1100, 1'b0, 1'b1, 5);
        sync_reset = 1'b0;
        until_cyc(base + 19);
        stage_ack = 4'b0001;
        until_cyc(base + 120);
        sync_reset = 1'b1;
        repeat (2) @(negedge clk);

        // T6: ack[1] arrives exactly on the timeout edge 88 -> advance wins
        stage_ack = 4'b0000;
        base = cyc + 1;
        expect_at(base + 24, 4'b1100, 1'b0, 1'b0, 6);
        expect_at(base + 87, 4'b1100, 1'b0, 1'b0, 6);
        expect_at(base + 88, 4'b1000, 1'b0, 1'b0, 6);
        expect_at(base + 103, 4'b1000, 1'b0, 1'b0, 6);
        expect_at(base + 104, 4'b0000, 1'b0, 1'b0, 6);
        expect_at(base + 119, 4'b0000, 1'b0, 1'b0, 6);
        expect_at(base + 120, 4'b0000, 1'b1, 1'b0, 6);
        expect_at(base + 170, 4'b0000, 1'b1, 1'b0, 6);
        sync_reset = 1'b0;
        until_cyc(base + 19);
        stage_ack = 4'b0001;
        until_cyc(base + 87);
        stage_ack = 4'b1111;
        until_cyc(base + 170);
        sync_reset = 1'b1;
`endif

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset-release controller that consumes the active-high synchronised reset produced by the reset synchroniser and deasserts up to NUM_STAGES downstream reset lines one at a time, in index order, with programmable spacing. An optional acknowledge handshake holds each release until the previous stage reports ready. A timeout and error flag cover the case where a stage never acknowledges. The block sits directly downstream of `reset_sync` (OUTPUT_POLARITY=1) and drives the per-subsystem resets.

## Interface
- NUM_STAGES, 4, number of sequenced reset outputs (≥1)
- HOLD_CYCLES, 8, cycles all outputs stay asserted after sync_reset_i falls (≥1)
- STAGE_DELAY, 16, minimum cycles between consecutive releases, and from the last release to done_o (≥1)
- TIMEOUT_CYCLES, 64, ack wait limit measured from a stage's release (> STAGE_DELAY)
- clk  input  1  sole clock; all logic on its rising edge
- sync_reset_i  input  1  reset, synchronous and active-high
- stage_ack_i  input  NUM_STAGES  per-stage ready acknowledge; used only with ack mode compiled in
- stage_reset_o  output  NUM_STAGES  per-stage reset, active-high, registered
- done_o  output  1  sequence complete, registered
- error_o  output  1  ack timeout occurred, registered

## Operation
- States: HOLD, WAIT, DONE, ERROR. A stage index k (0..NUM_STAGES-1) and one cycle counter, width $clog2(max(HOLD_CYCLES,STAGE_DELAY,TIMEOUT_CYCLES)+1), drive the sequence.
- sync_reset_i=1 at an edge, from any state or mid-sequence: state HOLD, counter 0, k=0, stage_reset_o all ones, done_o=0, error_o=0. The block stays there while sync_reset_i remains high.
- HOLD: the counter increments each edge. When HOLD_CYCLES is reached, stage_reset_o[0] is cleared, the counter is reset, and the state moves to WAIT with k=0.
- WAIT (time mode): after STAGE_DELAY cycles, the next stage is released (k+1), or the state moves to DONE if k=NUM_STAGES-1.
- WAIT (ack mode): the advance happens at the first edge where counter ≥ STAGE_DELAY and stage_ack_i[k] is sampled 1.
- WAIT (ack mode), timeout: if the counter reaches TIMEOUT_CYCLES with no qualifying ack, the state moves to ERROR.
- WAIT (ack mode), simultaneous event: an ack sampled on the timeout edge wins, and the stage advances with no error.
- DONE: done_o=1. Absorbing until sync_reset_i.
- ERROR: error_o=1. Already-released stages stay released and the remaining stages stay in reset. Absorbing until sync_reset_i.
- Released stages never re-assert except through sync_reset_i.
- stage_ack_i bits for stages not yet released are ignored.

## Timing
- Let t0 be the first edge where sync_reset_i is sampled 0.
- stage_reset_o[0] falls at edge t0+HOLD_CYCLES, denoted r0.
- Time mode:
  - stage k falls at r(k-1)+STAGE_DELAY.
  - done_o rises at r(N-1)+STAGE_DELAY.
- Ack mode:
  - stage k falls at the first edge e ≥ r(k-1)+STAGE_DELAY where stage_ack_i[k-1] is sampled 1.
  - done_o is gated the same way by stage_ack_i[N-1].
  - error_o rises at r(k)+TIMEOUT_CYCLES if no qualifying ack has arrived.
- All outputs are registered, with zero combinational input-to-output paths.
- Reset takes effect at the same edge sync_reset_i is sampled 1.

## Configuration
- RESET_SEQ_ACK_EN defined: ack mode as above.
- RESET_SEQ_ACK_EN undefined: time mode only.
  - stage_ack_i is ignored.
  - error_o is tied 0 and the ERROR state and timeout logic are removed.
  - Port list is unchanged.

## Test plan
Defaults NUM_STAGES=4, HOLD_CYCLES=8, STAGE_DELAY=16, TIMEOUT_CYCLES=64; t0=edge 0.
- Time mode, sync_reset_i released -> stage_reset_o = 1110 at 8, 1100 at 24, 1000 at 40, 0000 at 56; done_o=1 at 72; error_o=0 throughout.
- Time mode, sync_reset_i high at edge 30 then low from edge 35 -> edge 30 gives 1111 and done_o=0; stage 0 falls at 43; subsequent releases at 59, 75, 91.
- Ack mode, stage_ack_i[0] first sampled 1 at edge 40 -> stage 1 falls at 40, not 24; stage_ack_i[0] high at edge 20 -> stage 1 falls at 24.
- Ack mode, stage_ack_i[1] held 0 after stage 1 falls at 24 -> error_o=1 at 88; stage_reset_o stays 1100; done_o=0; state persists until sync_reset_i.
- Ack mode, stage_ack_i[1] first sampled 1 exactly at edge 88 -> stage 2 falls at 88; error_o remains 0.
- sync_reset_i held high for 200 cycles -> stage_reset_o=1111, done_o=0, error_o=0 every cycle.
